// File: rtl/led_sched_pkg.sv
// Shared types and default constants for the LED step scheduler.
// Optional single-step support is selected with LED_SCHED_SINGLE_STEP_EN.
package led_sched_pkg;

    // Encodings are visible on the mode output, so they are fixed.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } sched_state_e;

    localparam int unsigned LED_SCHED_CNT_W          = 32;
    localparam int unsigned LED_SCHED_DEFAULT_PERIOD = 5_000_000;
    localparam int unsigned LED_SCHED_MIN_PERIOD     = 1_000;
    localparam int unsigned LED_SCHED_MAX_PERIOD     = 50_000_000;

endpackage

// File: rtl/led_step_scheduler_if.sv
// Key-logic <-> scheduler bundle: request pulses in, step pulse and status out.
// step_req exists only when LED_SCHED_SINGLE_STEP_EN is defined.
interface led_step_scheduler_if #(
    parameter int unsigned CNT_W = 32
) ();

    // Requests are single-cycle pulses sampled on clk. There is no ready:
    // every request is consumed on the edge that samples it; a request the
    // current mode has no use for is dropped. step_en is a one-cycle pulse
    // with no back-pressure from the sweep FSM.
    logic             run_req;
    logic             pause_req;
    logic             stop_req;
    logic             speed_up;
    logic             speed_down;
    logic             speed_rst;
`ifdef LED_SCHED_SINGLE_STEP_EN
    logic             step_req;
`endif
    logic             step_en;
    logic [CNT_W-1:0] period;
    logic [1:0]       mode;

    modport master (
        output run_req, pause_req, stop_req, speed_up, speed_down, speed_rst,
`ifdef LED_SCHED_SINGLE_STEP_EN
        output step_req,
`endif
        input  step_en, period, mode
    );

    modport slave (
        input  run_req, pause_req, stop_req, speed_up, speed_down, speed_rst,
`ifdef LED_SCHED_SINGLE_STEP_EN
        input  step_req,
`endif
        output step_en, period, mode
    );

endinterface

// File: rtl/led_sched_period_reg.sv
// Step-period register: speed request priority plus halve/double with clamping.
module led_sched_period_reg
    import led_sched_pkg::*;
#(
    parameter int unsigned CNT_W          = LED_SCHED_CNT_W,
    parameter int unsigned DEFAULT_PERIOD = LED_SCHED_DEFAULT_PERIOD,
    parameter int unsigned MIN_PERIOD     = LED_SCHED_MIN_PERIOD,
    parameter int unsigned MAX_PERIOD     = LED_SCHED_MAX_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             speed_up,
    input  logic             speed_down,
    input  logic             speed_rst,
    output logic [CNT_W-1:0] period
);

    localparam logic [CNT_W-1:0] DEF_W = CNT_W'(DEFAULT_PERIOD);
    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W:0]   MAX_W = (CNT_W+1)'(MAX_PERIOD);

    logic [CNT_W-1:0] halved;
    logic [CNT_W:0]   doubled;

    // The extra bit keeps a doubled period from wrapping before the clamp.
    assign halved  = period >> 1;
    assign doubled = {period, 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period <= DEF_W;
        end else if (speed_rst) begin
            period <= DEF_W;
        end else if (speed_up && !speed_down) begin
            period <= (halved < MIN_W) ? MIN_W : halved;
        end else if (speed_down && !speed_up) begin
            period <= (doubled > MAX_W) ? MAX_W[CNT_W-1:0] : doubled[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/led_step_scheduler.sv
// Run/pause/stop scheduler producing a one-cycle step_en every `period` clocks.
// Define LED_SCHED_SINGLE_STEP_EN to allow single steps while paused.
module led_step_scheduler
    import led_sched_pkg::*;
#(
    parameter int unsigned CNT_W          = LED_SCHED_CNT_W,
    parameter int unsigned DEFAULT_PERIOD = LED_SCHED_DEFAULT_PERIOD,
    parameter int unsigned MIN_PERIOD     = LED_SCHED_MIN_PERIOD,
    parameter int unsigned MAX_PERIOD     = LED_SCHED_MAX_PERIOD
) (
    input  logic                 clk,
    input  logic                 reset,
    led_step_scheduler_if.slave  bus
);

    sched_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic             step_q;

    led_sched_period_reg #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD),
        .MIN_PERIOD     (MIN_PERIOD),
        .MAX_PERIOD     (MAX_PERIOD)
    ) u_period (
        .clk        (clk),
        .reset      (reset),
        .speed_up   (bus.speed_up),
        .speed_down (bus.speed_down),
        .speed_rst  (bus.speed_rst),
        .period     (period_q)
    );

    // The counter only advances on edges where the FSM stays in RUN, so
    // the edge that pauses or resumes leaves the held count untouched.
    // The compare uses the registered period, so a same-cycle speed change
    // takes effect from the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (bus.run_req) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (bus.stop_req) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (bus.pause_req) begin
                        state_q <= S_PAUSE;
                    end else if (cnt_q >= period_q - CNT_W'(1)) begin
                        cnt_q  <= '0;
                        step_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (bus.stop_req) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (bus.run_req) begin
                        state_q <= S_RUN;
`ifdef LED_SCHED_SINGLE_STEP_EN
                    end else if (bus.step_req) begin
                        cnt_q  <= '0;
                        step_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.step_en = step_q;
    assign bus.period  = period_q;
    assign bus.mode    = state_q;

endmodule

// File: tb/tb_led_step_scheduler.sv
// Bench for led_step_scheduler: directed scenarios with literal expectations
// plus random pulses checked every cycle against a behavioural model.
module tb_led_step_scheduler;

    localparam int CNT_W = 8;
    localparam int DEF   = 4;
    localparam int MINP  = 2;
    localparam int MAXP  = 16;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_step_scheduler_if #(.CNT_W(CNT_W)) bus ();

    led_step_scheduler #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEF),
        .MIN_PERIOD     (MINP),
        .MAX_PERIOD     (MAXP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- behavioural model ----------------
    int m_mode, m_cnt, m_period;
    bit m_step;

    function automatic void model_next(
        input  int mode, cnt, per,
        input  bit run, pause, stop, up, down, srst, step,
        output int nmode, ncnt, nper,
        output bit nstep);
        nmode = mode;
        ncnt  = cnt;
        nper  = per;
        nstep = 1'b0;
        // Only requests that mean something in the current mode compete.
        if (stop && mode != 0)       nmode = 0;
        else if (pause && mode == 1) nmode = 2;
        else if (run && mode != 1)   nmode = 1;
        if (nmode == 0) begin
            ncnt = 0;
        end else if (mode == 1 && nmode == 1) begin
            if (cnt + 1 >= per) begin
                ncnt  = 0;
                nstep = 1'b1;
            end else begin
                ncnt = cnt + 1;
            end
        end else if (mode == 2 && nmode == 2 && step) begin
            ncnt  = 0;
            nstep = 1'b1;
        end
        if (srst)           nper = DEF;
        else if (up && !down) nper = (per / 2 < MINP) ? MINP : per / 2;
        else if (down && !up) nper = (per * 2 > MAXP) ? MAXP : per * 2;
    endfunction

    always @(posedge clk or posedge reset) begin
        int nm, nc, np;
        bit ns, sreq;
        if (reset) begin
            m_mode   <= 0;
            m_cnt    <= 0;
            m_period <= DEF;
            m_step   <= 1'b0;
        end else begin
`ifdef LED_SCHED_SINGLE_STEP_EN
            sreq = bus.step_req;
`else
            sreq = 1'b0;
`endif
            model_next(m_mode, m_cnt, m_period, bus.run_req, bus.pause_req,
                       bus.stop_req, bus.speed_up, bus.speed_down, bus.speed_rst,
                       sreq, nm, nc, np, ns);
            m_mode   <= nm;
            m_cnt    <= nc;
            m_period <= np;
            m_step   <= ns;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (bus.step_en !== m_step) begin
                errors++;
                $display("FAIL cmp_step_en cyc=%0d got %0b want %0b", cyc, bus.step_en, m_step);
            end
            checks++;
            if (bus.mode !== 2'(m_mode)) begin
                errors++;
                $display("FAIL cmp_mode cyc=%0d got %0d want %0d", cyc, bus.mode, m_mode);
            end
            checks++;
            if (bus.period !== 8'(m_period)) begin
                errors++;
                $display("FAIL cmp_period cyc=%0d got %0d want %0d", cyc, bus.period, m_period);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.run_req    = 1'b0;
        bus.pause_req  = 1'b0;
        bus.stop_req   = 1'b0;
        bus.speed_up   = 1'b0;
        bus.speed_down = 1'b0;
        bus.speed_rst  = 1'b0;
`ifdef LED_SCHED_SINGLE_STEP_EN
        bus.step_req   = 1'b0;
`endif
    endtask

    // Called at a negedge; presents one cycle of pulses, returns at the next negedge.
    task automatic drive(input bit run, pause, stop, up, down, srst, step);
        bus.run_req    = run;
        bus.pause_req  = pause;
        bus.stop_req   = stop;
        bus.speed_up   = up;
        bus.speed_down = down;
        bus.speed_rst  = srst;
`ifdef LED_SCHED_SINGLE_STEP_EN
        bus.step_req   = step;
`else
        if (step) bus.speed_rst = srst;
`endif
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic idle(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.step_en) pulses++;
        end
    endtask

    // ---------------- scoreboard for pulse timing ----------------
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    initial begin
        int c0, np;
        int down_exp[5];
        down_exp = '{4, 8, 16, 16, 16};

        reset = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        chk("reset_step_en", int'(bus.step_en), 0);
        chk("reset_mode", int'(bus.mode), 0);
        chk("reset_period", int'(bus.period), 4);
        reset = 1'b0;

        // Run from IDLE: pulses after E4, E8, E12.
        drive(1, 0, 0, 0, 0, 0, 0);
        c0 = cyc;
        chk("run_mode", int'(bus.mode), 1);
        exp_q = '{8'd4, 8'd8, 8'd12};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.step_en) obs_q.push_back(8'(cyc - c0));
        end
        chk("pulse_count", obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk("pulse_edge", int'(obs_q.pop_front()), int'(exp_q.pop_front()));

        // Pause with count 2, hold, resume: first pulse two edges later.
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("pause_mode", int'(bus.mode), 2);
        idle(10, np);
        chk("pause_no_pulse", np, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("resume_e0", int'(bus.step_en), 0);
        idle(1, np);
        chk("resume_e1", np, 0);
        idle(1, np);
        chk("resume_e2", np, 1);

        // Speed arithmetic and saturation.
        drive(0, 0, 1, 0, 0, 0, 0);
        chk("stop_mode", int'(bus.mode), 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 0, 0);
            chk("speed_up_period", int'(bus.period), 2);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            chk("speed_down_period", int'(bus.period), down_exp[i]);
        end
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("speed_rst_period", int'(bus.period), 4);

        // Shrink the period below the running count.
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("period_8", int'(bus.period), 8);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(6, np);
        chk("no_pulse_before_6", np, 0);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("shrink_period", int'(bus.period), 4);
        chk("shrink_no_pulse_yet", int'(bus.step_en), 0);
        idle(1, np);
        chk("shrink_pulse", np, 1);
        idle(3, np);
        chk("after_shrink_gap", np, 0);
        idle(1, np);
        chk("after_shrink_next", np, 1);

        // Simultaneous stop/pause/run, then conflicting speed requests.
        idle(1, np);
        drive(1, 1, 1, 0, 0, 0, 0);
        chk("all_req_mode", int'(bus.mode), 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(3, np);
        chk("restart_gap", np, 0);
        idle(1, np);
        chk("restart_from_zero", np, 1);
        drive(0, 0, 0, 1, 1, 0, 0);
        chk("up_down_ignored", int'(bus.period), 4);

        // Paused: single step if built in, otherwise nothing.
        drive(0, 1, 0, 0, 0, 0, 0);
        chk("pause2_mode", int'(bus.mode), 2);
        drive(0, 0, 0, 0, 0, 0, 1);
`ifdef LED_SCHED_SINGLE_STEP_EN
        chk("single_step", int'(bus.step_en), 1);
`else
        chk("single_step_absent", int'(bus.step_en), 0);
`endif
        idle(5, np);
        chk("single_step_once", np, 0);
        drive(0, 0, 1, 0, 0, 0, 0);

        // Random pulses, checked by the per-cycle compare.
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
                  $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 1,
                  $urandom_range(0, 99) < 8);
        end

        // Asynchronous reset while step_en is high.
        drive(0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        idle(7, np);
        chk("pre_reset_gap", np, 0);
        @(posedge clk);
        #1;
        chk("pre_reset_step", int'(bus.step_en), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_step_en", int'(bus.step_en), 0);
        chk("async_mode", int'(bus.mode), 0);
        chk("async_period", int'(bus.period), 4);
        @(negedge clk);
        reset = 1'b0;
        idle(6, np);
        chk("post_reset_idle", np, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_step_scheduler.md
# led_step_scheduler

Sequences the bouncing-LED sweep controller by generating its single-cycle advance enable (`step_en`) at a programmable rate. It also owns the run/pause/stop mode and the step period, which the front-panel keys adjust with speed requests. It sits between the key-input logic and the LED sweep FSM, so the sweep no longer advances on every clock.

## Interface
- `CNT_W`, 32: width of the period register and the cycle counter.
- `DEFAULT_PERIOD`, 5_000_000: period loaded at reset and on `speed_rst`, in clk cycles.
- `MIN_PERIOD`, 1_000: lower bound on the period. Must be ≥ 2.
- `MAX_PERIOD`, 50_000_000: upper bound on the period. Must be < 2^CNT_W.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `run_req`  in  1  pulse: start stepping, or resume stepping.
- `pause_req`  in  1  pulse: freeze stepping and hold the counter.
- `stop_req`  in  1  pulse: return to IDLE and clear the counter.
- `speed_up`  in  1  pulse: halve the period.
- `speed_down`  in  1  pulse: double the period.
- `speed_rst`  in  1  pulse: reload `DEFAULT_PERIOD`.
- `step_req`  in  1  pulse: single step while paused. Present only with `LED_SCHED_SINGLE_STEP_EN`.
- `step_en`  out  1  registered one-cycle advance pulse to the LED sweep FSM.
- `period`  out  CNT_W  current period.
- `mode`  out  2  current state: IDLE=0, RUN=1, PAUSE=2.

## Operation
- Reset values: `mode`=IDLE, counter=0, `period`=DEFAULT_PERIOD, `step_en`=0.
- State transitions:
  - IDLE→RUN on `run_req`.
  - RUN→PAUSE on `pause_req`.
  - PAUSE→RUN on `run_req`.
  - RUN or PAUSE→IDLE on `stop_req`.
  - A request with no transition from the current state is ignored.
- Mode request priority when several arrive in the same cycle: stop > pause > run.
- Counter behaviour:
  - IDLE: held at 0.
  - PAUSE: holds its value.
  - RUN: increments each cycle. When counter ≥ `period`−1, counter goes to 0 and `step_en` is set for one cycle.
- Using ≥ in the compare means that shrinking the period below the current count fires at the next edge rather than wrapping.
- Entering RUN from PAUSE resumes from the held count. Entering RUN from IDLE starts from 0.
- Period update priority: `speed_rst` > `speed_up` > `speed_down`. If `speed_up` and `speed_down` arrive in the same cycle without `speed_rst`, both are ignored.
- Period arithmetic:
  - `speed_up`: new period = max(period>>1, MIN_PERIOD).
  - `speed_down`: period<<1 is computed in CNT_W+1 bits, then clamped to MAX_PERIOD.
- Speed requests are accepted in every mode, including IDLE.
- A speed change and a terminal count in the same cycle: the compare uses the old period. The new period applies from the next cycle.
- A stop in the same cycle as a terminal count: no `step_en`, and the counter goes to 0.

## Timing
- `step_en` is registered. With the period fixed at P, `run_req` sampled at edge E0 (entering from IDLE) gives `step_en` high during the cycle after edge E0+P, then again every P cycles.
- `mode` and `period` update on the edge that samples the request, so they are visible in the next cycle.
- Asserting `reset` mid-operation clears everything immediately. `step_en` drops asynchronously.
- Inputs are single-cycle synchronous pulses. Holding a request high repeats it every cycle; a held speed request saturates at the bound.

## Configuration
- Macro: `LED_SCHED_SINGLE_STEP_EN`.
- Defined:
  - `step_req` port exists.
  - In PAUSE, `step_req` produces one `step_en` pulse on the next edge and clears the counter.
  - In RUN or IDLE, `step_req` is ignored.
  - A `step_req` in the same cycle as `run_req` or `stop_req` is ignored in favour of the mode change.
- Undefined: the `step_req` port is absent and PAUSE never produces `step_en`.

## Structure
- Package `led_sched_pkg`: the state enum (IDLE/RUN/PAUSE with the encodings above) and the default-period constants.
- Sub-module `led_sched_period_reg` holds the period register, request priority and clamp arithmetic. Its ports are clk, reset, the three speed pulses and `period`.
- The top level holds the mode FSM, the counter and the `step_en` register.

## Test plan
All scenarios use CNT_W=8, DEFAULT_PERIOD=4, MIN_PERIOD=2, MAX_PERIOD=16.
- Reset then `run_req` at E0 → `step_en` pulses after edges E4, E8 and E12. `mode`=1.
- `pause_req` with counter=2, hold 10 cycles, then `run_req` → no pulses while paused; the first pulse comes 2 cycles after resume.
- `speed_up` ×3 → `period` 2, 2, 2. Then `speed_down` ×5 → 4, 8, 16, 16, 16. Then `speed_rst` → 4.
- Counter=6 with period=8, then `speed_up` → `period`=4; pulse at the next edge and counter=0.
- `stop_req`, `pause_req` and `run_req` in the same cycle while in RUN → `mode`=IDLE and counter=0. `speed_up` and `speed_down` together → `period` unchanged.
- With `LED_SCHED_SINGLE_STEP_EN`: in PAUSE, `step_req` → exactly one `step_en`. In RUN, `step_req` has no extra effect. Asserting `reset` mid-RUN → all outputs return to their reset values.
